// File: rtl/gate_sensor_decoder.sv
// gate_sensor_decoder
//   Turns the two raw break-beam sensors of the single entry/exit lane into
//   clean one-cycle Sense_In / Sense_Out pulses for the occupancy FSM.
//   Beam A is street side, beam B is garage side; direction comes from the
//   A/B blocking order. Glitches, reversals, partial crossings and stuck
//   beams never pulse; illegal sequences and stalls are flagged via fault.
//
//   Ports
//     clk          system clock, rising edge
//     rst_n        asynchronous active-low reset
//     beam_a_raw   street-side beam, 1 = blocked, asynchronous
//     beam_b_raw   garage-side beam, 1 = blocked, asynchronous
//     enable       0 = decoder held idle, no pulses
//     Sense_In     one-cycle pulse per completed entry
//     Sense_Out    one-cycle pulse per completed exit
//     busy         crossing in progress
//     fault        high while in FAULT

// Per-beam front end: 2-flop synchronizer followed by a consecutive-cycle
// debounce. Raw-to-filtered latency is 2 + DEBOUNCE cycles.
module gsd_beam_filter #(
   parameter int unsigned DEBOUNCE = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic filt
);
   logic       s1_q, s1_d;
   logic       s2_q, s2_d;
   logic       f_q, f_d;
   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      s1_d  = raw;
      s2_d  = s1_q;
      f_d   = f_q;
      cnt_d = '0;
      // Counter only advances while the synchronized level disagrees with
      // the accepted level; any agreeing cycle restarts the count.
      if (s2_q != f_q) begin
         if (cnt_q == 8'(DEBOUNCE - 1)) begin
            f_d = s2_q;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         f_q   <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         f_q   <= f_d;
         cnt_q <= cnt_d;
      end
   end

   assign filt = f_q;
endmodule

module gate_sensor_decoder #(
   parameter int unsigned DEBOUNCE = 16,
   parameter int unsigned TIMEOUT  = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic beam_a_raw,
   input  logic beam_b_raw,
   input  logic enable,
   output logic Sense_In,
   output logic Sense_Out,
   output logic busy,
   output logic fault
);
   localparam int NUM_BEAMS = 2;
   localparam int TMO_W     = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_IN_A,
      S_IN_AB,
      S_IN_B,
      S_OUT_B,
      S_OUT_BA,
      S_OUT_A,
      S_FAULT
   } state_e;

   // Index 1 = beam A, index 0 = beam B, so beam_f reads as {a_f,b_f}.
   logic [NUM_BEAMS-1:0] beam_raw;
   logic [NUM_BEAMS-1:0] beam_f;

   assign beam_raw = {beam_a_raw, beam_b_raw};

   for (genvar g = 0; g < NUM_BEAMS; g++) begin : g_beam
      gsd_beam_filter #(.DEBOUNCE(DEBOUNCE)) u_filt (
         .clk  (clk),
         .rst_n(rst_n),
         .raw  (beam_raw[g]),
         .filt (beam_f[g])
      );
   end

   state_e           state_q, state_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             sense_in_q, sense_in_d;
   logic             sense_out_q, sense_out_d;
   logic             crossing;

   assign crossing = (state_q != S_IDLE) && (state_q != S_FAULT);

   always_comb begin
      state_d     = state_q;
      sense_in_d  = 1'b0;
      sense_out_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            case (beam_f)
               2'b10:   state_d = S_IN_A;
               2'b01:   state_d = S_OUT_B;
               2'b11:   state_d = S_FAULT;
               default: ;
            endcase
         end
         S_IN_A: begin
            case (beam_f)
               2'b11:   state_d = S_IN_AB;
               2'b00:   state_d = S_IDLE;   // backed out
               2'b01:   state_d = S_FAULT;
               default: ;
            endcase
         end
         S_IN_AB: begin
            case (beam_f)
               2'b01:   state_d = S_IN_B;
               2'b10:   state_d = S_IN_A;
               2'b00:   state_d = S_FAULT;
               default: ;
            endcase
         end
         S_IN_B: begin
            case (beam_f)
               2'b00: begin
                  state_d    = S_IDLE;
                  sense_in_d = 1'b1;
               end
               2'b11:   state_d = S_IN_AB;
               2'b10:   state_d = S_FAULT;
               default: ;
            endcase
         end
         S_OUT_B: begin
            case (beam_f)
               2'b11:   state_d = S_OUT_BA;
               2'b00:   state_d = S_IDLE;   // backed out
               2'b10:   state_d = S_FAULT;
               default: ;
            endcase
         end
         S_OUT_BA: begin
            case (beam_f)
               2'b10:   state_d = S_OUT_A;
               2'b01:   state_d = S_OUT_B;
               2'b00:   state_d = S_FAULT;
               default: ;
            endcase
         end
         S_OUT_A: begin
            case (beam_f)
               2'b00: begin
                  state_d     = S_IDLE;
                  sense_out_d = 1'b1;
               end
               2'b11:   state_d = S_OUT_BA;
               2'b01:   state_d = S_FAULT;
               default: ;
            endcase
         end
         S_FAULT: begin
            if (beam_f == 2'b00) state_d = S_IDLE;
         end
         default: state_d = S_FAULT;
      endcase

      // A stalled crossing wins over whatever the beams say this cycle.
      if (crossing && (tmo_q >= TMO_W'(TIMEOUT - 1))) begin
         state_d     = S_FAULT;
         sense_in_d  = 1'b0;
         sense_out_d = 1'b0;
      end

      // Disable wins over everything, including a pulse about to issue.
      if (!enable) begin
         state_d     = S_IDLE;
         sense_in_d  = 1'b0;
         sense_out_d = 1'b0;
      end

      // Dwell counter measures time spent in the current crossing state.
      if (crossing && (state_d == state_q)) begin
         tmo_d = tmo_q + TMO_W'(1);
      end else begin
         tmo_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         tmo_q       <= '0;
         sense_in_q  <= 1'b0;
         sense_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         sense_in_q  <= sense_in_d;
         sense_out_q <= sense_out_d;
      end
   end

   assign Sense_In  = sense_in_q;
   assign Sense_Out = sense_out_q;
   assign busy      = crossing;
   assign fault     = (state_q == S_FAULT);
endmodule

// File: tb/tb_gate_sensor_decoder.sv
// Directed bench for gate_sensor_decoder with DEBOUNCE=4, TIMEOUT=64.
// Raw-to-filtered latency is 6 cycles; a completing release shows its pulse
// 7 cycles after the raw edge.
module tb_gate_sensor_decoder;
   logic clk = 1'b0;
   logic rst_n;
   logic beam_a_raw, beam_b_raw, enable;
   logic Sense_In, Sense_Out, busy, fault;

   int errs   = 0;
   int checks = 0;
   int in_cnt = 0, out_cnt = 0, both_cnt = 0;
   int b_in, b_out;
   logic busy_seen;

   gate_sensor_decoder #(.DEBOUNCE(4), .TIMEOUT(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .beam_a_raw(beam_a_raw),
      .beam_b_raw(beam_b_raw),
      .enable    (enable),
      .Sense_In  (Sense_In),
      .Sense_Out (Sense_Out),
      .busy      (busy),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (Sense_In)  in_cnt++;
      if (Sense_Out) out_cnt++;
      if (Sense_In && Sense_Out) both_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic mark();
      b_in  = in_cnt;
      b_out = out_cnt;
   endtask

   task automatic chk_counts(input string tag, input int e_in, input int e_out);
      chk({tag, "_nin"},  in_cnt - b_in,   e_in);
      chk({tag, "_nout"}, out_cnt - b_out, e_out);
   endtask

   initial begin
      rst_n = 1'b0; beam_a_raw = 1'b0; beam_b_raw = 1'b0; enable = 1'b1;
      tick(3);
      chk("rst_sense_in",  Sense_In,  0);
      chk("rst_sense_out", Sense_Out, 0);
      chk("rst_busy",      busy,      0);
      chk("rst_fault",     fault,     0);
      rst_n = 1'b1;
      tick(5);

      // Entry: A, AB, B, release.
      mark();
      beam_a_raw = 1; tick(10); chk("entry_busy_a",  busy, 1);
      beam_b_raw = 1; tick(10); chk("entry_busy_ab", busy, 1);
      beam_a_raw = 0; tick(10); chk("entry_busy_b",  busy, 1);
      beam_b_raw = 0; tick(6);
      chk("entry_pre",      Sense_In, 0);
      chk("entry_pre_busy", busy,     1);
      tick(1);
      chk("entry_pulse",      Sense_In,  1);
      chk("entry_pulse_out",  Sense_Out, 0);
      chk("entry_idle_busy",  busy,      0);
      tick(1);
      chk("entry_width", Sense_In, 0);
      tick(5);
      chk_counts("entry", 1, 0);

      // Exit: mirror.
      mark();
      beam_b_raw = 1; tick(10); chk("exit_busy_b",  busy, 1);
      beam_a_raw = 1; tick(10); chk("exit_busy_ba", busy, 1);
      beam_b_raw = 0; tick(10); chk("exit_busy_a",  busy, 1);
      beam_a_raw = 0; tick(6);
      chk("exit_pre", Sense_Out, 0);
      tick(1);
      chk("exit_pulse",    Sense_Out, 1);
      chk("exit_pulse_in", Sense_In,  0);
      tick(1);
      chk("exit_width", Sense_Out, 0);
      tick(5);
      chk_counts("exit", 0, 1);

      // Glitch: 3-cycle blip on A must never reach the FSM.
      mark();
      busy_seen = 1'b0;
      beam_a_raw = 1; tick(3); beam_a_raw = 0;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         busy_seen = busy_seen | busy;
      end
      chk("glitch_busy", busy_seen, 0);
      chk_counts("glitch", 0, 0);

      // Back-out: A only, then release.
      mark();
      beam_a_raw = 1; tick(10); chk("backout_busy", busy, 1);
      beam_a_raw = 0; tick(10); chk("backout_idle", busy, 0);
      chk_counts("backout", 0, 0);

      // Reversal: A, AB, back to A, release; then a full entry.
      mark();
      beam_a_raw = 1; tick(10);
      beam_b_raw = 1; tick(10);
      beam_b_raw = 0; tick(10); chk("rev_busy_a", busy, 1);
      beam_a_raw = 0; tick(10); chk("rev_idle",   busy, 0);
      chk("rev_fault", fault, 0);
      chk_counts("rev", 0, 0);
      mark();
      beam_a_raw = 1; tick(10);
      beam_b_raw = 1; tick(10);
      beam_a_raw = 0; tick(10);
      beam_b_raw = 0; tick(15);
      chk_counts("rev_entry", 1, 0);

      // Timeout: A held; IN_A entered 7 cycles after the raw edge, fault 64 later.
      mark();
      beam_a_raw = 1; tick(70);
      chk("tmo_pre_fault", fault, 0);
      chk("tmo_pre_busy",  busy,  1);
      tick(1);
      chk("tmo_fault",      fault, 1);
      chk("tmo_fault_busy", busy,  0);
      tick(9);
      beam_a_raw = 0; tick(6);
      chk("tmo_hold_fault", fault, 1);
      tick(1);
      chk("tmo_clear", fault, 0);
      chk("tmo_idle",  busy,  0);
      chk_counts("tmo", 0, 0);

      // Simultaneous A and B.
      mark();
      beam_a_raw = 1; beam_b_raw = 1; tick(10);
      chk("both_fault", fault, 1);
      chk("both_busy",  busy,  0);
      beam_a_raw = 0; beam_b_raw = 0; tick(10);
      chk("both_clear", fault, 0);
      chk_counts("both", 0, 0);

      // Disable while in IN_B, then release beams.
      mark();
      beam_a_raw = 1; tick(10);
      beam_b_raw = 1; tick(10);
      beam_a_raw = 0; tick(10);
      enable = 0; tick(2);
      chk("dis_busy", busy, 0);
      beam_b_raw = 0; tick(10);
      enable = 1; tick(5);
      chk("dis_reen_busy",  busy,  0);
      chk("dis_reen_fault", fault, 0);
      chk_counts("dis", 0, 0);

      // Disable in the very cycle the completing pulse is scheduled.
      mark();
      beam_a_raw = 1; tick(10);
      beam_b_raw = 1; tick(10);
      beam_a_raw = 0; tick(10);
      beam_b_raw = 0; tick(6);
      enable = 0; tick(1);
      chk("dis_sched_pulse", Sense_In, 0);
      tick(3);
      enable = 1; tick(3);
      chk_counts("dis_sched", 0, 0);

      // Re-enable picks up current filtered levels.
      mark();
      enable = 0; beam_a_raw = 1; tick(10);
      chk("reen_dis_busy", busy, 0);
      enable = 1; tick(2);
      chk("reen_in_a", busy, 1);
      beam_a_raw = 0; tick(10);
      chk("reen_idle", busy, 0);
      chk_counts("reen", 0, 0);

      // Reset mid-crossing.
      mark();
      beam_a_raw = 1; tick(10);
      beam_b_raw = 1; tick(10);
      chk("rmid_busy_pre", busy, 1);
      rst_n = 0; #1;
      chk("rmid_busy",      busy,      0);
      chk("rmid_fault",     fault,     0);
      chk("rmid_sense_in",  Sense_In,  0);
      chk("rmid_sense_out", Sense_Out, 0);
      beam_a_raw = 0; beam_b_raw = 0; tick(3);
      rst_n = 1; tick(15);
      chk("rmid_after_busy", busy, 0);
      chk_counts("rmid", 0, 0);

      chk("never_both", both_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
